// File: rtl/programmable_clock_divider_if.sv
// Configuration and output bundle for programmable_clock_divider.
// Handshake: load[i] is a one-cycle strobe sampled on the rising inputCLK edge; the divider always
// accepts it (no ready), and pending[i] stays high until the captured values become active.
interface programmable_clock_divider_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16
);
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] divider;
  logic [CHANNELS*WIDTH-1:0] highCount;
  logic [CHANNELS-1:0]       outputCLK;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       pending;

  modport master (
    output enable, load, divider, highCount,
    input  outputCLK, tick, pending
  );

  modport slave (
    input  enable, load, divider, highCount,
    output outputCLK, tick, pending
  );
endinterface

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable divided-clock / tick generator. Ratio and high-time changes are
// shadowed and only take effect where a new period starts, so no period is ever truncated.
module programmable_clock_divider #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                         inputCLK,
  input  logic                         reset,
  programmable_clock_divider_if.slave  bus
);

  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_DIV / 2);
  localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(2);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] div_in, high_in, div_eff;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d, high_q, high_d;
    logic [WIDTH-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d;
    logic             pend_q, pend_d, out_q, out_d, tick_q, tick_d, run_q;
    logic             boundary;

    assign div_in  = bus.divider[i*WIDTH +: WIDTH];
    assign high_in = bus.highCount[i*WIDTH +: WIDTH];

    always_comb begin
      count_d  = count_q;
      div_d    = div_q;
      high_d   = high_q;
      sdiv_d   = sdiv_q;
      shigh_d  = shigh_q;
      pend_d   = pend_q;
      div_eff  = (div_q < MIN_DIV) ? MIN_DIV : div_q;

      // A channel that was idle last cycle restarts at count 0 rather than advancing.
      if (!bus.enable[i] || !run_q || (count_q >= div_eff - WIDTH'(1))) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end

      // Every count_d==0 edge opens a fresh period, including idle edges.
      boundary = (count_d == '0);

      if (boundary) begin
        if (bus.load[i]) begin
          div_d   = div_in;
          high_d  = high_in;
          sdiv_d  = div_in;
          shigh_d = high_in;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          div_d   = sdiv_q;
          high_d  = shigh_q;
          pend_d  = 1'b0;
        end
      end else if (bus.load[i]) begin
        sdiv_d  = div_in;
        shigh_d = high_in;
        pend_d  = 1'b1;
      end

      out_d  = bus.enable[i] && (count_d < high_d);
      tick_d = bus.enable[i] && boundary;
    end

    always_ff @(posedge inputCLK or negedge reset) begin
      if (!reset) begin
        count_q <= '0;
        div_q   <= DEF_DIV;
        high_q  <= DEF_HIGH;
        sdiv_q  <= DEF_DIV;
        shigh_q <= DEF_HIGH;
        pend_q  <= 1'b0;
        out_q   <= 1'b0;
        tick_q  <= 1'b0;
        run_q   <= 1'b0;
      end else begin
        count_q <= count_d;
        div_q   <= div_d;
        high_q  <= high_d;
        sdiv_q  <= sdiv_d;
        shigh_q <= shigh_d;
        pend_q  <= pend_d;
        out_q   <= out_d;
        tick_q  <= tick_d;
        run_q   <= bus.enable[i];
      end
    end

    assign bus.outputCLK[i] = out_q;
    assign bus.tick[i]      = tick_q;
    assign bus.pending[i]   = pend_q;
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Bench for programmable_clock_divider: a period-level waveform model feeds an expected queue,
// and an independent monitor pops and compares one entry per clock edge.
module tb_programmable_clock_divider;
  localparam int CH  = 2;
  localparam int W   = 16;
  localparam int DEF = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  programmable_clock_divider_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  programmable_clock_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .inputCLK (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  // Scoreboard: {pending[1:0], tick[1:0], outputCLK[1:0]} expected after each edge.
  logic [3*CH-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: each period is laid out in full as a list of {tick, clk} cycles.
  int       m_div[CH], m_high[CH], m_sdiv[CH], m_shigh[CH];
  bit       m_pend[CH], m_run[CH];
  bit [1:0] wave_q[CH][$];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_div[c]   = DEF;
      m_high[c]  = DEF / 2;
      m_sdiv[c]  = DEF;
      m_shigh[c] = DEF / 2;
      m_pend[c]  = 1'b0;
      m_run[c]   = 1'b0;
      wave_q[c].delete();
    end
  endfunction

  function automatic void model_new_period(int c);
    if (bus.load[c]) begin
      m_div[c]   = int'(bus.divider[c*W +: W]);
      m_high[c]  = int'(bus.highCount[c*W +: W]);
      m_sdiv[c]  = m_div[c];
      m_shigh[c] = m_high[c];
      m_pend[c]  = 1'b0;
    end else if (m_pend[c]) begin
      m_div[c]  = m_sdiv[c];
      m_high[c] = m_shigh[c];
      m_pend[c] = 1'b0;
    end
  endfunction

  function automatic logic [3*CH-1:0] model_edge();
    logic [CH-1:0] o_clk, o_tick, o_pend;
    for (int c = 0; c < CH; c++) begin
      int d;
      if (!bus.enable[c]) begin
        wave_q[c].delete();
        m_run[c] = 1'b0;
        model_new_period(c);
        o_clk[c]  = 1'b0;
        o_tick[c] = 1'b0;
      end else begin
        if (!m_run[c] || wave_q[c].size() == 0) begin
          wave_q[c].delete();
          model_new_period(c);
          d = (m_div[c] < 2) ? 2 : m_div[c];
          for (int k = 0; k < d; k++) wave_q[c].push_back({k == 0, k < m_high[c]});
        end else if (bus.load[c]) begin
          m_sdiv[c]  = int'(bus.divider[c*W +: W]);
          m_shigh[c] = int'(bus.highCount[c*W +: W]);
          m_pend[c]  = 1'b1;
        end
        {o_tick[c], o_clk[c]} = wave_q[c].pop_front();
        m_run[c] = 1'b1;
      end
      o_pend[c] = m_pend[c];
    end
    return {o_pend, o_tick, o_clk};
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs set; predicts the next rising edge, then advances one cycle.
  task automatic step();
    exp_q.push_back(model_edge());
    @(posedge clk);
    @(negedge clk);
    bus.load = '0;
  endtask

  task automatic set_ch(int c, int dv, int hc);
    bus.divider[c*W +: W]   = W'(dv);
    bus.highCount[c*W +: W] = W'(hc);
    bus.load[c]             = 1'b1;
  endtask

  function automatic int dut_outs();
    return int'({bus.pending, bus.tick, bus.outputCLK});
  endfunction

  // Monitor
  logic [3*CH-1:0] mon_exp, mon_got;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {bus.pending, bus.tick, bus.outputCLK};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL edge_outputs pend/tick/clk got=%b exp=%b t=%0t", mon_got, mon_exp, $time);
      end
    end
  end

  initial begin
    bus.enable    = '0;
    bus.load      = '0;
    bus.divider   = '0;
    bus.highCount = '0;
    model_reset();

    #12;
    check("reset_state", dut_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default ratio on channel 0
    bus.enable[0] = 1'b1;
    repeat (25) step();

    // Reprogram mid-period: old period completes, then 4-cycle periods
    for (int g = 0; g < 20 && wave_q[0].size() != 6; g++) step();
    set_ch(0, 4, 1);
    step();
    repeat (20) step();

    // Degenerate divider and duty extremes
    set_ch(0, 1, 0);
    step();
    repeat (12) step();
    set_ch(0, 3, 7);
    step();
    repeat (12) step();

    // Two loads in one period, then a load on the boundary edge
    for (int g = 0; g < 10 && wave_q[0].size() != 2; g++) step();
    set_ch(0, 6, 3);
    step();
    set_ch(0, 8, 4);
    step();
    set_ch(0, 5, 2);
    step();
    repeat (12) step();

    // Async reset in the middle of a 20-cycle period on channel 1
    bus.enable[1] = 1'b1;
    set_ch(1, 20, 10);
    step();
    repeat (7) step();
    #1 rst_n = 1'b0;
    #1 check("async_reset_immediate", dut_outs(), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_held", dut_outs(), 0);
    rst_n = 1'b1;
    repeat (25) step();

    // Concurrent channels; disable and re-enable channel 0 mid-period
    set_ch(0, 3, 1);
    set_ch(1, 7, 3);
    step();
    repeat (10) step();
    for (int g = 0; g < 10 && wave_q[0].size() != 1; g++) step();
    bus.enable[0] = 1'b0;
    repeat (3) step();
    bus.enable[0] = 1'b1;
    repeat (12) step();

    // Randomized loads and enable changes
    repeat (400) begin
      if ($urandom_range(0, 15) == 0) bus.enable[$urandom_range(0, CH-1)] ^= 1'b1;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) set_ch(c, int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
      step();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/programmable_clock_divider.md
Name: programmable_clock_divider

Overview:
- Multi-channel, runtime-programmable clock-enable/divided-clock generator; successor to the fixed-ratio single-output divider.
- Each channel has its own divide ratio, high-time (duty), enable, and start-of-period tick.
- Ratio and duty updates are shadowed and applied only at a period boundary, so outputs never glitch or produce truncated periods.
- Sits between the system clock and slow peripherals (UART baud, PWM, LED scan) that need software-adjustable rates.

Parameters:
- CHANNELS, 2, number of independent divider channels.
- WIDTH, 16, width of per-channel counter, divider and highCount fields.
- DEFAULT_DIV, 10, active divide ratio for every channel after reset; must be ≥2 and <2^WIDTH.

Ports:
- inputCLK  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  CHANNELS  per-channel run enable; bit i controls channel i.
- load  input  CHANNELS  per-channel one-cycle strobe; captures divider/highCount slice i into shadow.
- divider  input  CHANNELS*WIDTH  requested period in inputCLK cycles; slice i = bits [i*WIDTH +: WIDTH].
- highCount  input  CHANNELS*WIDTH  requested high cycles per period, same slicing.
- outputCLK  output  CHANNELS  registered divided clock per channel.
- tick  output  CHANNELS  registered one-cycle pulse in the first cycle of each period.
- pending  output  CHANNELS  1 while a loaded shadow value awaits transfer to active.

Behaviour:
- Reset (reset=0, async):
  - count=0; outputCLK=0; tick=0; pending=0.
  - divActive = shadowDiv = DEFAULT_DIV; highActive = shadowHigh = DEFAULT_DIV/2 (integer).
  - All of the above take effect immediately, including mid-period. Release is sampled at the next inputCLK edge.
- Effective divider: divEff = max(divActive, 2). Values 0 and 1 are treated as 2; no combinational clock pass-through.
- Running channel (enable=1), per rising edge:
  - count advances 0,1,…,divEff-1, then wraps to 0.
  - Registered outputs track the new count value: outputCLK = (count_next < highActive); tick = (count_next == 0).
  - Period is exactly divEff cycles.
  - Duty rules: highActive=0 → outputCLK constant 0. highActive ≥ divEff → outputCLK constant 1. tick still pulses once per period in both cases.
- Boundary: the edge where count == divEff-1, i.e. count_next=0.
  - At that edge, if pending=1: divActive←shadowDiv, highActive←shadowHigh, pending←0.
  - The new values govern the period starting at count 0, including that first cycle's outputCLK.
- Load (load[i]=1 at an edge):
  - shadowDiv/shadowHigh ← the input slices; pending←1.
  - Load while pending already 1: shadow is overwritten; the last load before the boundary wins.
  - Load on a boundary edge: the loaded values go straight to active for the new period; pending=0.
  - Load while disabled: values transfer to active at that edge; pending=0.
- Disabled (enable=0):
  - count←0, outputCLK←0, tick←0 on the next edge.
  - A running period is abandoned; this is the only sanctioned truncation.
- Enable 0→1: at the first enabled edge count_next=0, tick=1, outputCLK=(highActive>0). Output is a full period from this edge.
- Channels are fully independent. No shared state; no cross-channel phase alignment guaranteed.
- All arithmetic is unsigned WIDTH-bit. Counter never exceeds divEff-1. Shrinking the divider never strands count, because changes apply only at count_next=0.

Test Plan:
- Reset release, enable[0]=1, no load → outputCLK[0] period 10 cycles, high 5 cycles (counts 0–4), tick[0] every 10th cycle starting at the first enabled edge.
- load[0] with divider=4, highCount=1 at count=3 of a 10-cycle period → pending[0]=1 until the boundary; the old period completes 10 cycles; subsequent periods are 4 cycles with 1 high; pending[0]=0 after the boundary.
- divider=1, highCount=0 → period 2, outputCLK constant 0, tick every 2 cycles. Then highCount=7, divider=3 → outputCLK constant 1, tick every 3 cycles.
- Two loads (div=6, then div=8) within one period, then a load coincident with the boundary edge (div=5) → next period is 5 cycles, pending=0 throughout the boundary cycle.
- reset pulsed low mid-period on channel 1 with divider=20 loaded → all outputs 0 immediately (asynchronously); after release the channel runs at DEFAULT_DIV, not 20.
- Channel 0 div=3 and channel 1 div=7 run concurrently; channel 0 disabled mid-period → channel 0 outputs go to 0 next edge; channel 1 period and tick unchanged; re-enable gives an immediate tick on channel 0.
